// File: rtl/action_encoder.sv
// Encodes per-action enable vectors back into 4-bit action indices, one beat per set line,
// served round-robin from a persistent pointer. Flags zero-hot and multi-hot vectors.
module action_encoder #(
  parameter int N_ACT  = 15,
  parameter int CODE_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ACT-1:0]  en_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] at_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              multi_hot,
  output logic              zero_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int IW = CODE_W + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [N_ACT-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0]  ptr_q, ptr_d;
  logic               multi_hot_q, multi_hot_d;
  logic               zero_err_q, zero_err_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [CODE_W-1:0]  sel;
  logic [N_ACT-1:0]   sel_mask;
  logic [N_ACT-1:0]   pending_left;
  logic               is_multi;

  // Rotated priority search: first set pending bit at or above ptr, wrapping past the top line.
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_ACT; k++) begin
      idx = {1'b0, ptr_q} + IW'(k);
      if (idx >= IW'(N_ACT)) begin
        idx = idx - IW'(N_ACT);
      end
      if (!found && pending_q[idx[CODE_W-1:0]]) begin
        sel   = idx[CODE_W-1:0];
        found = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_ACT; gi++) begin : g_sel_mask
      assign sel_mask[gi] = (sel == CODE_W'(gi));
    end
  endgenerate

  assign pending_left = pending_q & ~sel_mask;
  assign is_multi     = |(en_in & (en_in - N_ACT'(1)));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    multi_hot_d = 1'b0;
    zero_err_d  = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (en_in == '0) begin
            zero_err_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
          end else begin
            pending_d   = en_in;
            multi_hot_d = is_multi;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_d = pending_left;
          ptr_d     = (sel == CODE_W'(N_ACT - 1)) ? '0 : sel + CODE_W'(1);
          if (pending_left == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ptr_q       <= '0;
      multi_hot_q <= 1'b0;
      zero_err_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      multi_hot_q <= multi_hot_d;
      zero_err_q  <= zero_err_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DRAIN);
  assign at_out    = out_valid ? sel : '0;
  assign multi_hot = multi_hot_q;
  assign zero_err  = zero_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_action_encoder.sv
// Randomized and directed bench for action_encoder; expected beats come from a
// round-robin sweep model over the accepted vector.
module tb_action_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] en_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  at_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        multi_hot;
  logic        zero_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  int obs_q[$];
  int m_ptr = 0;
  int m_err = 0;
  bit m_mh = 0;

  action_encoder dut (
    .clk(clk), .rst(rst), .en_in(en_in), .in_valid(in_valid), .in_ready(in_ready),
    .at_out(at_out), .out_valid(out_valid), .out_ready(out_ready),
    .multi_hot(multi_hot), .zero_err(zero_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic string q2s(input int q[$]);
    string s = "{";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return {s, "}"};
  endfunction

  // Beats of a vector are its set lines in sweep order from the pointer.
  function automatic void model_accept(input logic [14:0] v);
    exp_q.delete();
    m_mh = ($countones(v) > 1);
    if (v == 15'h0) begin
      if (m_err < 255) m_err++;
    end else begin
      for (int k = 0; k < 15; k++) begin
        int i;
        i = (m_ptr + k) % 15;
        if (v[i]) exp_q.push_back(i);
      end
      m_ptr = (exp_q[$] + 1) % 15;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_err = 0;
  endtask

  task automatic send_vec(input logic [14:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    en_in = v; in_valid = 1'b1;
    model_accept(v);
    $display("accept en_in=%04h", v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit rnd);
    int n = 0;
    obs_q.delete();
    while (out_valid && n < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) obs_q.push_back(int'(at_out));
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    if (out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
    checks++; if (at_out !== 4'd0) begin errors++; $display("FAIL reset_at_out: got %0d exp 0", at_out); end
    checks++; if ({multi_hot, zero_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {multi_hot, zero_err}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d exp 0", err_count); end
  endtask

  task automatic test_single();
    send_vec(15'h0004);
    checks++; if (out_valid !== 1'b1 || at_out !== 4'd2) begin errors++; $display("FAIL single_first: out_valid=%0b at_out=%0d exp 1/2", out_valid, at_out); end
    checks++; if (in_ready !== 1'b0 || multi_hot !== 1'b0) begin errors++; $display("FAIL single_flags: in_ready=%0b multi_hot=%0b exp 0/0", in_ready, multi_hot); end
    collect(1'b0);
    checks++; if (obs_q.size() != 1 || obs_q[0] != 2) begin errors++; $display("FAIL single_beats: got %s exp {2 }", q2s(obs_q)); end
    checks++; if (in_ready !== 1'b1 || at_out !== 4'd0) begin errors++; $display("FAIL single_idle: in_ready=%0b at_out=%0d exp 1/0", in_ready, at_out); end
  endtask

  task automatic test_multi_hot();
    do_reset();
    send_vec(15'h4001);
    checks++; if (multi_hot !== 1'b1 || at_out !== 4'd0) begin errors++; $display("FAIL multi_pulse: multi_hot=%0b at_out=%0d exp 1/0", multi_hot, at_out); end
    collect(1'b0);
    checks++; if (obs_q.size() != 2 || obs_q[0] != 0 || obs_q[1] != 14) begin errors++; $display("FAIL multi_beats: got %s exp {0 14 }", q2s(obs_q)); end
    checks++; if (multi_hot !== 1'b0) begin errors++; $display("FAIL multi_one_cycle: multi_hot=%0b exp 0", multi_hot); end
  endtask

  task automatic test_round_robin();
    send_vec(15'h0011);
    collect(1'b0);
    checks++; if (obs_q.size() != 2 || obs_q[0] != 0 || obs_q[1] != 4) begin errors++; $display("FAIL rr_first: got %s exp {0 4 }", q2s(obs_q)); end
    send_vec(15'h0021);
    collect(1'b0);
    checks++; if (obs_q.size() != 2 || obs_q[0] != 5 || obs_q[1] != 0) begin errors++; $display("FAIL rr_second: got %s exp {5 0 }", q2s(obs_q)); end
  endtask

  task automatic test_backpressure();
    send_vec(15'h0300);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || at_out !== 4'd8) begin errors++; $display("FAIL bp_hold%0d: out_valid=%0b at_out=%0d exp 1/8", i, out_valid, at_out); end
      @(negedge clk);
    end
    collect(1'b0);
    checks++; if (obs_q.size() != 2 || obs_q[0] != 8 || obs_q[1] != 9) begin errors++; $display("FAIL bp_beats: got %s exp {8 9 }", q2s(obs_q)); end
  endtask

  task automatic test_zero_hot();
    do_reset();
    send_vec(15'h0000);
    checks++; if (zero_err !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL zero_first: zero_err=%0b err_count=%0d exp 1/1", zero_err, err_count); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || at_out !== 4'd0) begin errors++; $display("FAIL zero_idle: out_valid=%0b in_ready=%0b at_out=%0d exp 0/1/0", out_valid, in_ready, at_out); end
    @(negedge clk);
    checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL zero_pulse: zero_err=%0b exp 0", zero_err); end
    for (int i = 1; i < 300; i++) send_vec(15'h0000);
    checks++; if (err_count !== 8'(m_err) || m_err != 255) begin errors++; $display("FAIL zero_saturate: err_count=%0d exp 255", err_count); end
  endtask

  task automatic test_random();
    logic [14:0] v;
    bit          same;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 7))
        0:       v = 15'h0000;
        1:       v = 15'h0001 << $urandom_range(0, 14);
        default: v = 15'($urandom);
      endcase
      send_vec(v);
      checks++; if (multi_hot !== m_mh || zero_err !== (v == 15'h0) || err_count !== 8'(m_err)) begin
        errors++; $display("FAIL rand_flags%0d: mh=%0b ze=%0b err=%0d exp %0b/%0b/%0d", t, multi_hot, zero_err, err_count, m_mh, (v == 15'h0), m_err);
      end
      collect(1'b1);
      same = (obs_q.size() == exp_q.size());
      foreach (exp_q[i]) if (same && obs_q[i] != exp_q[i]) same = 0;
      checks++; if (!same) begin errors++; $display("FAIL rand_beats%0d: got %s exp %s", t, q2s(obs_q), q2s(exp_q)); end
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    send_vec(15'h0000);
    send_vec(15'h7FFF);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    m_ptr = 0; m_err = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || at_out !== 4'd0) begin errors++; $display("FAIL rst_mid_state: out_valid=%0b in_ready=%0b at_out=%0d exp 0/1/0", out_valid, in_ready, at_out); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_mid_err: err_count=%0d exp 0", err_count); end
    send_vec(15'h4002);
    collect(1'b0);
    checks++; if (obs_q.size() != 2 || obs_q[0] != 1 || obs_q[1] != 14) begin errors++; $display("FAIL rst_mid_ptr: got %s exp {1 14 }", q2s(obs_q)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_hot();
    test_round_robin();
    test_backpressure();
    test_zero_hot();
    test_random();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
